intan_fifo_drain_arb: RTL and testbench

- Read-side sequencer for the two Intan byte FIFOs (lane 1 = fifoi_rxd[15:8], lane 0 = fifoi_rxd[7:0]).
- On each start handshake, drains exactly the per-lane frame length implied by dev_kind, lane 0 first, then lane 1.
- Merges both lanes into one registered byte stream for the downstream packet/ADC path.
- Closes with the codebase's level fs/fd handshake. Lanes with length 0 are skipped.

---
 rtl/intan_fifo_drain_arb_pkg.sv | 32 +++
 rtl/intan_fifo_drain_arb_lane_counter.sv | 41 ++++
 rtl/intan_fifo_drain_arb.sv | 149 ++++++++++++++
 tb/tb_intan_fifo_drain_arb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intan_fifo_drain_arb_pkg.sv
// Shared constants for the Intan FIFO drain sequencer: one-hot state codes,
// frame lengths, header byte and the dev_kind -> lane length decode.
package intan_pkg;

  localparam logic [7:0] ST_IDLE  = 8'h01;
  localparam logic [7:0] ST_SEL   = 8'h02;
  localparam logic [7:0] ST_READ  = 8'h04;
  localparam logic [7:0] ST_FLUSH = 8'h08;
  localparam logic [7:0] ST_DONE  = 8'h10;

  localparam logic [11:0] LEN_32 = 12'h020;
  localparam logic [11:0] LEN_64 = 12'h040;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  typedef struct packed {
    logic [11:0] len1;
    logic [11:0] len0;
  } lane_lens_t;

  function automatic lane_lens_t decode_lens(input logic [1:0] dev_kind);
    lane_lens_t l;
    case (dev_kind)
      2'b01:   begin l.len1 = LEN_32; l.len0 = 12'h000; end
      2'b10:   begin l.len1 = LEN_64; l.len0 = 12'h000; end
      2'b11:   begin l.len1 = LEN_64; l.len0 = LEN_64;  end
      default: begin l.len1 = 12'h000; l.len0 = 12'h000; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intan_fifo_drain_arb_lane_counter.sv
// Byte counter for the lane being drained plus the consecutive-stall counter
// that raises a one-cycle timeout when TIMEOUT stall cycles have accumulated.
module intan_lane_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        rd,
  input  logic        stall_en,
  input  logic [11:0] len,
  output logic        owed,
  output logic        done,
  output logic        timeout
);

  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  logic [11:0] cnt;
  logic [11:0] stall_cnt;
  logic        stall;

  assign owed    = (cnt != len);
  assign stall   = stall_en && owed;
  assign done    = rd && ((cnt + 12'd1) == len);
  // Fires on the TIMEOUT-th consecutive stall cycle, not one cycle later.
  assign timeout = stall && (stall_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt       <= 12'd0;
      stall_cnt <= 12'd0;
    end else if (rd) begin
      cnt       <= cnt + 12'd1;
      stall_cnt <= 12'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 12'd1;
    end
  end

endmodule

// File: rtl/intan_fifo_drain_arb.sv
// Drains lane 0 then lane 1 of the Intan byte FIFOs into one registered stream.
// Define INTAN_DRAIN_HDR_EN to prefix each drained lane with a 0xA0|lane beat.
module intan_fifo_drain_arb
  import intan_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dev_kind,
  input  logic        fs,
  output logic        fd,
  input  logic [15:0] fifo_rxd,
  input  logic [1:0]  fifo_empty,
  output logic [1:0]  fifo_rxen,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        lane,
  output logic        err,
  output logic [7:0]  dbg_state
);

  // Handshake: fs is a level from the controller; a frame starts when fs is
  // seen high in IDLE, fd rises once the frame is fully emitted and stays high
  // until fs is seen low, which returns the block to IDLE with fd low.

  logic [7:0]  state, state_next;
  logic        cur, cur_next;
  logic [11:0] len0_q, len1_q, len_cur;
  logic [1:0]  flush_cnt;
  logic        abort_q;
  logic        rd_q, lane_q;
  logic        hdr_active, hdr_q;
  logic        rd, clr, stall_en, owed, done, timeout;
  lane_lens_t  lens;

  assign lens      = decode_lens(dev_kind);
  assign len_cur   = cur ? len1_q : len0_q;
  assign dbg_state = state;

  assign rd        = (state == ST_READ) && !hdr_active && !fifo_empty[cur] && owed;
  assign fifo_rxen = rd ? (cur ? 2'b10 : 2'b01) : 2'b00;
  assign stall_en  = (state == ST_READ) && !hdr_active && fifo_empty[cur];

  intan_lane_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .rd       (rd),
    .stall_en (stall_en),
    .len      (len_cur),
    .owed     (owed),
    .done     (done),
    .timeout  (timeout)
  );

`ifdef INTAN_DRAIN_HDR_EN
  logic hdr_pend;

  assign hdr_active = (state == ST_READ) && hdr_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_pend <= 1'b0;
      hdr_q    <= 1'b0;
    end else begin
      hdr_pend <= (state_next == ST_READ) && (state != ST_READ);
      hdr_q    <= hdr_active;
    end
  end
`else
  assign hdr_active = 1'b0;
  assign hdr_q      = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cur_next   = cur;
    clr        = 1'b0;
    case (state)
      ST_IDLE: if (fs) state_next = ST_SEL;
      ST_SEL: begin
        clr = 1'b1;
        if (len0_q != 12'd0) begin
          state_next = ST_READ;
          cur_next   = 1'b0;
        end else if (len1_q != 12'd0) begin
          state_next = ST_READ;
          cur_next   = 1'b1;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_READ: if (done || timeout) state_next = ST_FLUSH;
      ST_FLUSH: begin
        if (flush_cnt == 2'd1) begin
          // An aborted frame never moves on to lane 1.
          if (!cur && (len1_q != 12'd0) && !abort_q) begin
            state_next = ST_READ;
            cur_next   = 1'b1;
            clr        = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: if (!fs) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur       <= 1'b0;
      len0_q    <= 12'd0;
      len1_q    <= 12'd0;
      flush_cnt <= 2'd0;
      abort_q   <= 1'b0;
      fd        <= 1'b0;
      err       <= 1'b0;
      rd_q      <= 1'b0;
      lane_q    <= 1'b0;
      dout      <= 8'd0;
      dout_en   <= 1'b0;
      lane      <= 1'b0;
    end else begin
      state <= state_next;
      cur   <= cur_next;
      if (state == ST_IDLE && fs) begin
        len0_q <= lens.len0;
        len1_q <= lens.len1;
      end
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      if (state == ST_SEL) abort_q <= 1'b0;
      else if (timeout)    abort_q <= 1'b1;
      fd <= (state_next == ST_DONE);
      if (timeout) err <= 1'b1;
      // Two-stage pipe: stage 1 tags the read, stage 2 captures FIFO data.
      rd_q    <= (|fifo_rxen) || hdr_active;
      lane_q  <= cur;
      dout    <= hdr_q ? (HDR_BASE | {7'd0, lane_q})
                       : (lane_q ? fifo_rxd[15:8] : fifo_rxd[7:0]);
      dout_en <= rd_q;
      lane    <= lane_q;
    end
  end

endmodule

// File: tb/tb_intan_fifo_drain_arb.sv
// Bench for intan_fifo_drain_arb: FIFO model, table-driven frames, hand-built
// stall/timeout/reset sequences and randomized frames against a stream model.
module tb_intan_fifo_drain_arb;

`ifdef INTAN_DRAIN_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, fs, use_b;
  logic [1:0]  dev_kind;
  logic [15:0] fifo_rxd;
  logic [1:0]  fifo_empty;

  logic        fs_a, fs_b, fd_a, fd_b, en_a, en_b, ln_a, ln_b, err_a, err_b;
  logic [1:0]  emp_a, emp_b, rxen_a, rxen_b;
  logic [7:0]  dout_a, dout_b, st_a, st_b;
  logic        m_fd, m_en, m_lane, m_err;
  logic [1:0]  m_rxen;
  logic [7:0]  m_dout, m_state;

  always #5 clk = ~clk;

  // Two instances share the FIFO model; the idle one sees fs=0 and empty FIFOs.
  assign fs_a    = use_b ? 1'b0  : fs;
  assign fs_b    = use_b ? fs    : 1'b0;
  assign emp_a   = use_b ? 2'b11 : fifo_empty;
  assign emp_b   = use_b ? fifo_empty : 2'b11;
  assign m_fd    = use_b ? fd_b   : fd_a;
  assign m_en    = use_b ? en_b   : en_a;
  assign m_lane  = use_b ? ln_b   : ln_a;
  assign m_err   = use_b ? err_b  : err_a;
  assign m_rxen  = use_b ? rxen_b : rxen_a;
  assign m_dout  = use_b ? dout_b : dout_a;
  assign m_state = use_b ? st_b   : st_a;

  intan_fifo_drain_arb #(.TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .dev_kind(dev_kind), .fs(fs_a), .fd(fd_a),
    .fifo_rxd(fifo_rxd), .fifo_empty(emp_a), .fifo_rxen(rxen_a),
    .dout(dout_a), .dout_en(en_a), .lane(ln_a), .err(err_a), .dbg_state(st_a)
  );

  intan_fifo_drain_arb #(.TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .dev_kind(dev_kind), .fs(fs_b), .fd(fd_b),
    .fifo_rxd(fifo_rxd), .fifo_empty(emp_b), .fifo_rxen(rxen_b),
    .dout(dout_b), .dout_en(en_b), .lane(ln_b), .err(err_b), .dbg_state(st_b)
  );

  typedef struct {
    int         due;
    bit         ln;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [1:0] dk;
    int         pre0;
    int         pre1;
    int         beats;
    int         max_cyc;
    bit         rx0;
    bit         rx1;
  } vec_t;

  logic [7:0] q0[$], q1[$];
  logic [7:0] w0[$], w1[$];
  wr_t        wr_q[$];
  logic [8:0] got_q[$], exp_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, last_rd_cyc = -1, err_cyc = -1, last_en_cyc = -1, max_gap = 0;
  bit both_rxen, rx0_seen, rx1_seen;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic push(input bit ln, input logic [7:0] d);
    if (ln) begin q1.push_back(d); w1.push_back(d); end
    else    begin q0.push_back(d); w0.push_back(d); end
    fifo_empty = {q1.size() == 0, q0.size() == 0};
  endtask

  task automatic clear_fifos();
    q0.delete(); q1.delete(); w0.delete(); w1.delete(); wr_q.delete();
    fifo_empty = 2'b11;
  endtask

  // One clock: FIFO pops for the rxen seen at the edge, due writes, monitor.
  task automatic cycle();
    logic [1:0] r;
    #1;
    r = m_rxen;
    if (r == 2'b11) both_rxen = 1'b1;
    if (r[0]) rx0_seen = 1'b1;
    if (r[1]) rx1_seen = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    if (r != 2'b00) last_rd_cyc = cyc;
    if (r[0] && q0.size() > 0) fifo_rxd[7:0]  = q0.pop_front();
    if (r[1] && q1.size() > 0) fifo_rxd[15:8] = q1.pop_front();
    while (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
      wr_t w;
      w = wr_q.pop_front();
      push(w.ln, w.d);
    end
    fifo_empty = {q1.size() == 0, q0.size() == 0};
    @(negedge clk);
    if (m_en) begin
      got_q.push_back({m_lane, m_dout});
      if (last_en_cyc >= 0 && cyc - last_en_cyc > max_gap) max_gap = cyc - last_en_cyc;
      last_en_cyc = cyc;
    end
    if (m_err && err_cyc < 0) err_cyc = cyc;
  endtask

  function automatic void spec_lens(input logic [1:0] dk, output int l1, output int l0);
    case (dk)
      2'd1:    begin l1 = 32; l0 = 0;  end
      2'd2:    begin l1 = 64; l0 = 0;  end
      2'd3:    begin l1 = 64; l0 = 64; end
      default: begin l1 = 0;  l0 = 0;  end
    endcase
  endfunction

  // Stream model: lane 0 then lane 1, each up to its length; a short lane
  // (bytes never written) aborts the frame after what it did get.
  task automatic build_exp(input logic [1:0] dk);
    int  l[2];
    int  n;
    bit  abort;
    bit  lb;
    logic [7:0] b;
    spec_lens(dk, l[1], l[0]);
    exp_q.delete();
    abort = 1'b0;
    for (int ln = 0; ln < 2; ln++) begin
      if (!abort && l[ln] > 0) begin
        lb = (ln == 1);
        if (HDR != 0) exp_q.push_back({lb, 8'hA0 | {7'd0, lb}});
        n = lb ? w1.size() : w0.size();
        if (n >= l[ln]) n = l[ln];
        else abort = 1'b1;
        for (int i = 0; i < n; i++) begin
          b = lb ? w1[i] : w0[i];
          exp_q.push_back({lb, b});
        end
      end
    end
  endtask

  task automatic start_frame(input logic [1:0] dk);
    got_q.delete();
    both_rxen = 1'b0; rx0_seen = 1'b0; rx1_seen = 1'b0;
    last_en_cyc = -1; max_gap = 0; err_cyc = -1;
    dev_kind = dk;
    fs = 1'b1;
  endtask

  task automatic wait_fd(input int budget, output int n);
    n = 0;
    while (!m_fd && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic check_stream(input string nm, input logic [1:0] dk);
    int bad;
    build_exp(dk);
    check({nm, " beats"}, got_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0)
      $display("FAIL %s byte %0d: got %h required %h", nm, bad, got_q[bad], exp_q[bad]);
    check({nm, " first bad index"}, bad, -1);
  endtask

  task automatic end_frame(input string nm);
    fs = 1'b0;
    cycle();
    check({nm, " fd low after fs low"}, m_fd, 0);
    check({nm, " back to idle"}, m_state, 8'h01);
  endtask

  vec_t vecs[4];

  initial begin
    int n;
    int l0, l1, t;
    logic [1:0] dk;
    rst = 1'b1; fs = 1'b0; use_b = 1'b0; dev_kind = 2'd0;
    fifo_rxd = 16'd0; fifo_empty = 2'b11;
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("reset fd", m_fd, 0);
    check("reset dout_en", m_en, 0);
    check("reset dout", m_dout, 0);
    check("reset lane", m_lane, 0);
    check("reset err", m_err, 0);
    check("reset rxen", m_rxen, 0);
    check("reset state", m_state, 8'h01);

    vecs[0] = '{dk: 2'd3, pre0: 64, pre1: 64, beats: 128 + 2 * HDR, max_cyc: 400, rx0: 1, rx1: 1};
    vecs[1] = '{dk: 2'd1, pre0: 5,  pre1: 32, beats: 32 + HDR,      max_cyc: 200, rx0: 0, rx1: 1};
    vecs[2] = '{dk: 2'd0, pre0: 4,  pre1: 4,  beats: 0,             max_cyc: 3,   rx0: 0, rx1: 0};
    vecs[3] = '{dk: 2'd2, pre0: 0,  pre1: 64, beats: 64 + HDR,      max_cyc: 200, rx0: 0, rx1: 1};

    for (int v = 0; v < 4; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      clear_fifos();
      for (int i = 0; i < vecs[v].pre0; i++) push(1'b0, 8'(i));
      for (int i = 0; i < vecs[v].pre1; i++) push(1'b1, 8'(8'h40 + i));
      start_frame(vecs[v].dk);
      wait_fd(vecs[v].max_cyc, n);
      check({nm, " fd within budget"}, m_fd, 1);
      check({nm, " beat count"}, got_q.size(), vecs[v].beats);
      check_stream(nm, vecs[v].dk);
      check({nm, " rxen0 used"}, rx0_seen, vecs[v].rx0);
      check({nm, " rxen1 used"}, rx1_seen, vecs[v].rx1);
      check({nm, " rxen both"}, both_rxen, 0);
      check({nm, " err"}, m_err, 0);
      end_frame(nm);
    end

    // Lane 1 starved for well over 100 cycles, below TIMEOUT.
    clear_fifos();
    for (int i = 0; i < 16; i++) push(1'b1, 8'(8'h80 + i));
    for (int i = 16; i < 64; i++) wr_q.push_back('{due: cyc + 130, ln: 1'b1, d: 8'(8'h80 + i)});
    start_frame(2'd2);
    wait_fd(600, n);
    check("gap fd", m_fd, 1);
    check("gap beat count", got_q.size(), 64 + HDR);
    check_stream("gap", 2'd2);
    check("gap dout_en gap >= 100", max_gap >= 100, 1);
    check("gap err", m_err, 0);
    end_frame("gap");

    // Timeout on the TIMEOUT=16 instance: 10 of 64 bytes ever arrive.
    use_b = 1'b1;
    clear_fifos();
    for (int i = 0; i < 10; i++) push(1'b1, 8'(8'hC0 + i));
    start_frame(2'd2);
    wait_fd(200, n);
    check("timeout fd", m_fd, 1);
    check("timeout beat count", got_q.size(), 10 + HDR);
    check_stream("timeout", 2'd2);
    check("timeout err", m_err, 1);
    check("timeout stall cycles", err_cyc - last_rd_cyc, 16);
    end_frame("timeout");
    start_frame(2'd0);
    wait_fd(5, n);
    check("err sticky next frame", m_err, 1);
    end_frame("sticky");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("err cleared by rst", m_err, 0);
    use_b = 1'b0;

    // Reset in the middle of the lane 0 read.
    clear_fifos();
    for (int i = 0; i < 64; i++) push(1'b0, 8'(i));
    for (int i = 0; i < 64; i++) push(1'b1, 8'(8'h40 + i));
    start_frame(2'd3);
    repeat (20) cycle();
    rst = 1'b1; fs = 1'b0;
    cycle();
    rst = 1'b0;
    check("midrst fd", m_fd, 0);
    check("midrst dout_en", m_en, 0);
    check("midrst dout", m_dout, 0);
    check("midrst lane", m_lane, 0);
    check("midrst rxen", m_rxen, 0);
    check("midrst state", m_state, 8'h01);
    clear_fifos();
    cycle();

    // Random frames: trickled writes, dev_kind changed under a running frame.
    for (int f = 0; f < 8; f++) begin
      string nm;
      int rem0, rem1;
      nm = $sformatf("rand%0d", f);
      dk = 2'($urandom_range(0, 3));
      spec_lens(dk, l1, l0);
      clear_fifos();
      rem0 = l0; rem1 = l1;
      t = cyc + $urandom_range(0, 2);
      while (rem0 + rem1 > 0) begin
        bit ln;
        ln = (rem0 == 0) ? 1'b1 : (rem1 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        wr_q.push_back('{due: t, ln: ln, d: 8'($urandom_range(0, 255))});
        if (ln) rem1--; else rem0--;
        t += $urandom_range(0, 4);
      end
      start_frame(dk);
      cycle();
      cycle();
      dev_kind = 2'($urandom_range(0, 3));
      wait_fd(2000, n);
      check({nm, " fd"}, m_fd, 1);
      check_stream(nm, dk);
      check({nm, " rxen both"}, both_rxen, 0);
      check({nm, " err"}, m_err, 0);
      end_frame(nm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
